// File: rtl/seg_scan_mux.sv
// Four-digit time-multiplexed hex scanner feeding a seven-segment decoder.
// Optional leading-zero suppression is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_mux #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DIV_W       = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  blank,
    output logic [7:0]            digit_code,
    output logic [3:0]            an,
    output logic                  pending,
    output logic                  frame_tick
);

    localparam int unsigned VAL_W = 4 * DIGITS;
    localparam int unsigned IDX_W = 2;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VAL_W-1:0] shadow_q, shadow_d;
    logic [VAL_W-1:0] display_q, display_d;
    logic             pending_q, pending_d;
    logic [7:0]       digit_code_q, digit_code_d;
    logic [3:0]       an_q, an_d;
    logic             frame_tick_q, frame_tick_d;
    logic             tc;
    logic             frame_end;
    logic             lz_blank;
    logic [3:0]       nibble;

    // State registers; every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            display_q    <= '0;
            pending_q    <= 1'b0;
            digit_code_q <= 8'h00;
            an_q         <= 4'b1110;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            digit_code_q <= digit_code_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Next-state: prescaler, scan index, double buffer and output images.
    always_comb begin
        div_cnt_d    = div_cnt_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        display_d    = display_q;
        pending_d    = pending_q;
        lz_blank     = 1'b0;

        tc        = (div_cnt_q == DIV_W'(REFRESH_DIV - 1));
        frame_end = tc && (idx_q == IDX_W'(3));

        if (tc) begin
            div_cnt_d = '0;
            idx_d     = idx_q + IDX_W'(1);
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        // Boundary swap uses the old shadow; a coincident load refills it.
        if (frame_end && pending_q) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end

        nibble = display_d[{idx_d, 2'b00} +: 4];

`ifdef SEG_LZ_BLANK_EN
        case (idx_d)
            2'd1:    lz_blank = (display_d[15:4]  == 12'h000);
            2'd2:    lz_blank = (display_d[15:8]  == 8'h00);
            2'd3:    lz_blank = (display_d[15:12] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
`else
        lz_blank = 1'b0;
`endif

        digit_code_d = {4'b0000, nibble};
        an_d         = (blank || lz_blank) ? 4'b1111 : ~(4'b0001 << idx_d);
        frame_tick_d = frame_end;
    end

    assign digit_code = digit_code_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;

endmodule
